// File: rtl/debounce_pkg.sv
// debounce_pkg: shared FSM state type, width helpers and default timing constants.
package debounce_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, WAIT_EVT = 2'd2} state_e;
  localparam int TICK_DIV_DEF = 50000;
  localparam int STABLE_CNT_DEF = 5;
  function automatic int ch_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
  function automatic int scnt_w(input int n);
    return $clog2(n);
  endfunction
endpackage

// File: rtl/debounce_scan_ctrl_if.sv
// debounce_scan_ctrl_if: valid/ready key event stream (channel, new level).
interface debounce_scan_ctrl_if #(parameter int CH_W = 2) ();
  logic            evt_valid_o;
  logic            evt_ready_i;
  logic [CH_W-1:0] evt_ch_o;
  logic            evt_level_o;
  modport master (output evt_valid_o, evt_ch_o, evt_level_o, input evt_ready_i);
  modport slave  (input evt_valid_o, evt_ch_o, evt_level_o, output evt_ready_i);
endinterface

// File: rtl/debounce_tick_gen.sv
// debounce_tick_gen: sample-tick prescaler, one-cycle pulse every TICK_DIV enabled cycles.
import debounce_pkg::*;
module debounce_tick_gen #(
  parameter int TICK_DIV = TICK_DIV_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable_i,
  output logic tick_o
);
  localparam int CW = $clog2(TICK_DIV);
  logic [CW-1:0] r_cnt;
  assign tick_o = r_cnt == CW'(TICK_DIV - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_cnt <= '0;
    else r_cnt <= (!enable_i || tick_o) ? '0 : r_cnt + 1'b1;
endmodule

// File: rtl/debounce_scan_ctrl.sv
// debounce_scan_ctrl: round-robin multi-channel debouncer with event slot; DEBOUNCE_IRQ_EN adds irq_en_i/irq_o.
import debounce_pkg::*;
module debounce_scan_ctrl #(
  parameter int   CH_NUM     = 4,
  parameter int   TICK_DIV   = TICK_DIV_DEF,
  parameter int   STABLE_CNT = STABLE_CNT_DEF,
  parameter logic RST_LEVEL  = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable_i,
  input  logic [CH_NUM-1:0] key_i,
  output logic [CH_NUM-1:0] level_o,
  output logic              ovr_o,
  input  logic              ovr_clr_i,
`ifdef DEBOUNCE_IRQ_EN
  input  logic              irq_en_i,
  output logic              irq_o,
`endif
  debounce_scan_ctrl_if.master evt
);
  localparam int CH_W   = ch_w(CH_NUM);
  localparam int SCNT_W = scnt_w(STABLE_CNT);
  logic [CH_NUM-1:0] r_sync1, r_sync2, r_level;
  logic [SCNT_W-1:0] r_scnt [CH_NUM];
  state_e            r_state, w_state_nxt;
  logic [CH_W-1:0]   r_ch, w_ch_nxt, r_evt_ch;
  logic              w_tick, w_s, w_flip, w_full, w_last, w_eval, w_load;
  logic              r_evt_valid, r_evt_level, r_ovr;
  debounce_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk(clk), .rst_n(rst_n), .enable_i(enable_i), .tick_o(w_tick)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {r_sync2, r_sync1} <= {2 * CH_NUM{RST_LEVEL}};
    else {r_sync2, r_sync1} <= {r_sync1, key_i};
  assign w_s    = r_sync2[r_ch];
  assign w_full = r_evt_valid & ~evt.evt_ready_i;
  assign w_last = r_ch == CH_W'(CH_NUM - 1);
  assign w_flip = (w_s != r_level[r_ch]) && (r_scnt[r_ch] == SCNT_W'(STABLE_CNT - 1));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= IDLE;
      r_ch    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ch    <= w_ch_nxt;
    end
  always_comb begin
    w_state_nxt = r_state;
    w_ch_nxt    = r_ch;
    case (r_state)
      IDLE:     if (w_tick) begin
                  w_state_nxt = SCAN;
                  w_ch_nxt    = '0;
                end
      SCAN:     if (w_flip && w_full) w_state_nxt = WAIT_EVT;
                else if (w_last) w_state_nxt = IDLE;
                else w_ch_nxt = r_ch + 1'b1;
      WAIT_EVT: if (!w_full) w_state_nxt = SCAN;
      default:  w_state_nxt = IDLE;
    endcase
  end
  // a stalled flip leaves the channel untouched so it is re-evaluated after WAIT_EVT
  always_comb begin
    w_eval = (r_state == SCAN) && !(w_flip && w_full);
    w_load = w_eval && w_flip;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_level <= {CH_NUM{RST_LEVEL}};
      for (int i = 0; i < CH_NUM; i++) r_scnt[i] <= '0;
    end else if (w_eval) begin
      r_scnt[r_ch] <= (w_s == r_level[r_ch] || w_flip) ? '0 : r_scnt[r_ch] + 1'b1;
      if (w_flip) r_level[r_ch] <= w_s;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_evt_valid <= 1'b0;
      r_evt_ch    <= '0;
      r_evt_level <= 1'b0;
      r_ovr       <= 1'b0;
    end else begin
      r_evt_valid <= w_load | w_full;
      if (w_load) begin
        r_evt_ch    <= r_ch;
        r_evt_level <= w_s;
      end
      r_ovr <= (w_tick && r_state != IDLE) | (r_ovr & ~ovr_clr_i);
    end
`ifdef DEBOUNCE_IRQ_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) irq_o <= 1'b0;
    else irq_o <= irq_en_i & (r_evt_valid | r_ovr);
`endif
  assign level_o         = r_level;
  assign ovr_o           = r_ovr;
  assign evt.evt_valid_o = r_evt_valid;
  assign evt.evt_ch_o    = r_evt_ch;
  assign evt.evt_level_o = r_evt_level;
endmodule

// File: tb/tb_debounce_scan_ctrl.sv
// tb_debounce_scan_ctrl: directed scenarios with an event scoreboard for debounce_scan_ctrl.
module tb_debounce_scan_ctrl;
  import debounce_pkg::*;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable_i = 1'b1;
  logic       ovr_clr_i = 1'b0;
  logic [3:0] key_i = 4'hF;
  logic [3:0] level_o;
  logic       ovr_o;
`ifdef DEBOUNCE_IRQ_EN
  logic       irq_en_i = 1'b0;
  logic       irq_o;
  logic       irq_seen;
`endif
  int         n_chk = 0;
  int         n_fail = 0;
  logic [2:0] q[$];
  debounce_scan_ctrl_if #(.CH_W(2)) ev ();
  debounce_scan_ctrl #(.CH_NUM(4), .TICK_DIV(8), .STABLE_CNT(3), .RST_LEVEL(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .enable_i(enable_i), .key_i(key_i), .level_o(level_o),
    .ovr_o(ovr_o), .ovr_clr_i(ovr_clr_i),
`ifdef DEBOUNCE_IRQ_EN
    .irq_en_i(irq_en_i), .irq_o(irq_o),
`endif
    .evt(ev)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic wait_valid(input string tag);
    int k = 0;
    while (!ev.evt_valid_o && k < 80) begin
      cyc(1);
      k++;
    end
    chk(tag, 8'(ev.evt_valid_o), 8'd1);
  endtask
  always @(negedge clk)
    if (rst_n && ev.evt_valid_o && ev.evt_ready_i) begin
      chk("evt_expected", 8'(q.size() != 0), 8'd1);
      if (q.size() != 0) chk("evt_data", {5'd0, ev.evt_ch_o, ev.evt_level_o}, {5'd0, q.pop_front()});
    end
  initial begin
    ev.evt_ready_i = 1'b1;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_level", 8'(level_o), 8'hF);
    chk("rst_valid", 8'(ev.evt_valid_o), 8'd0);
    chk("rst_ovr", 8'(ovr_o), 8'd0);
    cyc(3);
    rst_n = 1'b1;
    cyc(2);
    chk("post_rst_level", 8'(level_o), 8'hF);
    chk("post_rst_valid", 8'(ev.evt_valid_o), 8'd0);
    q.push_back({2'd2, 1'b0});
    key_i[2] = 1'b0;
    cyc(44);
    chk("hold_level", 8'(level_o), 8'hB);
    chk("hold_q", 8'(q.size()), 8'd0);
    q.push_back({2'd2, 1'b1});
    key_i[2] = 1'b1;
    cyc(44);
    chk("release_level", 8'(level_o), 8'hF);
    key_i[1] = 1'b0;
    cyc(16);
    key_i[1] = 1'b1;
    cyc(24);
    chk("glitch_level", 8'(level_o), 8'hF);
    chk("glitch_scnt", 8'(dut.r_scnt[1]), 8'd0);
    chk("glitch_q", 8'(q.size()), 8'd0);
    ev.evt_ready_i = 1'b0;
    key_i[0] = 1'b0;
    key_i[3] = 1'b0;
    cyc(44);
    chk("stall_valid", 8'(ev.evt_valid_o), 8'd1);
    chk("stall_evt", {5'd0, ev.evt_ch_o, ev.evt_level_o}, 8'd0);
    chk("stall_state", 8'(dut.r_state), 8'(WAIT_EVT));
    chk("stall_ovr", 8'(ovr_o), 8'd1);
    chk("stall_level", 8'(level_o), 8'hE);
    q.push_back({2'd0, 1'b0});
    q.push_back({2'd3, 1'b0});
    ev.evt_ready_i = 1'b1;
    cyc(10);
    chk("drain_level", 8'(level_o), 8'h6);
    chk("drain_q", 8'(q.size()), 8'd0);
    chk("ovr_sticky", 8'(ovr_o), 8'd1);
    ovr_clr_i = 1'b1;
    cyc(1);
    ovr_clr_i = 1'b0;
    chk("ovr_clr", 8'(ovr_o), 8'd0);
    ev.evt_ready_i = 1'b0;
    key_i[0] = 1'b1;
    wait_valid("mid_valid");
    chk("mid_state", 8'(dut.r_state), 8'(SCAN));
    chk("mid_ch", 8'(dut.r_ch), 8'd1);
    key_i[3] = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 8'(ev.evt_valid_o), 8'd0);
    chk("mid_rst_level", 8'(level_o), 8'hF);
    cyc(3);
    rst_n = 1'b1;
    ev.evt_ready_i = 1'b1;
    q.push_back({2'd2, 1'b0});
    key_i[2] = 1'b0;
    cyc(44);
    chk("restart_level", 8'(level_o), 8'hB);
    chk("restart_q", 8'(q.size()), 8'd0);
`ifdef DEBOUNCE_IRQ_EN
    irq_en_i = 1'b1;
    ev.evt_ready_i = 1'b0;
    q.push_back({2'd2, 1'b1});
    key_i[2] = 1'b1;
    wait_valid("irq_valid");
    chk("irq_lag0", 8'(irq_o), 8'd0);
    cyc(1);
    chk("irq_rise", 8'(irq_o), 8'd1);
    ev.evt_ready_i = 1'b1;
    cyc(1);
    chk("irq_accept_valid", 8'(ev.evt_valid_o), 8'd0);
    chk("irq_hold", 8'(irq_o), 8'd1);
    cyc(1);
    chk("irq_fall", 8'(irq_o), 8'd0);
    irq_en_i = 1'b0;
    irq_seen = 1'b0;
    q.push_back({2'd2, 1'b0});
    key_i[2] = 1'b0;
    for (int i = 0; i < 44; i++) begin
      cyc(1);
      irq_seen |= irq_o;
    end
    chk("irq_off", 8'(irq_seen), 8'd0);
    chk("irq_off_level", 8'(level_o), 8'hB);
    q.push_back({2'd2, 1'b1});
`else
    q.push_back({2'd2, 1'b1});
`endif
    key_i[2] = 1'b1;
    cyc(44);
    chk("final_level", 8'(level_o), 8'hF);
    chk("final_q", 8'(q.size()), 8'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
